// File: rtl/custom_buff_mac_if.sv
// +--------------------------------------------------------------------------+
// | custom_buff_mac_if : operand-load / result handshake bundle              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface custom_buff_mac_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int ACC_W  = 18
);
    logic              feature_en;
    logic              weight_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic              start;
    logic              busy;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  acc_out;
    logic              sat;

    modport master (
        output feature_en, weight_en, addr, data_in, start, out_ready,
        input  busy, out_valid, acc_out, sat
    );

    modport slave (
        input  feature_en, weight_en, addr, data_in, start, out_ready,
        output busy, out_valid, acc_out, sat
    );
endinterface

`default_nettype wire

// File: rtl/custom_buff_mac.sv
// +--------------------------------------------------------------------------+
// | custom_buff_mac : LANES-wide operand buffer with sequential unsigned MAC |
// | Optional macro CUSTOM_MAC_SAT_EN clamps the accumulator instead of wrap. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module custom_buff_mac #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int ADDR_W = 2,
    parameter int ACC_W  = 18
) (
    input  wire logic          clk,
    input  wire logic          rst,
    custom_buff_mac_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   LANES_EXT = (ADDR_W+1)'(LANES);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LANES - 1);

    state_t              state;
    state_t              state_nxt;
    logic [DATA_W-1:0]   feature [LANES];
    logic [DATA_W-1:0]   weight  [LANES];
    logic [ADDR_W-1:0]   idx;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_next;
    logic [2*DATA_W-1:0] prod;
    logic                addr_ok;

    assign addr_ok = {1'b0, bus.addr} < LANES_EXT;
    assign prod    = feature[idx] * weight[idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.busy      = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Buffers only accept writes in IDLE so a running dot product sees frozen operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                feature[i] <= '0;
                weight[i]  <= '0;
            end
        end else if (state == IDLE && addr_ok) begin
            if (bus.feature_en) begin
                feature[bus.addr] <= bus.data_in;
            end
            if (bus.weight_en) begin
                weight[bus.addr] <= bus.data_in;
            end
        end
    end

`ifdef CUSTOM_MAC_SAT_EN
    logic [ACC_W:0] sum;
    logic           sat_q;

    assign sum = {1'b0, acc} + (ACC_W+1)'(prod);

    // Once clamped, the accumulator is pinned to all-ones until the next start.
    assign acc_next = (sat_q || sum[ACC_W]) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            sat_q <= 1'b0;
        end else if (state == RUN && sum[ACC_W]) begin
            sat_q <= 1'b1;
        end
    end

    assign bus.sat = sat_q;
`else
    assign acc_next = acc + ACC_W'(prod);
    assign bus.sat  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc <= '0;
                        idx <= '0;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.acc_out = acc;

endmodule

`default_nettype wire

// File: tb/tb_custom_buff_mac.sv
// +--------------------------------------------------------------------------+
// | tb_custom_buff_mac : randomized directed bench, 18-bit and 16-bit DUTs   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_custom_buff_mac;

    localparam int DATA_W = 8;
    localparam int LANES  = 4;
    localparam int ADDR_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    custom_buff_mac_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(18)) bus   ();
    custom_buff_mac_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(16)) bus16 ();

    assign bus16.feature_en = bus.feature_en;
    assign bus16.weight_en  = bus.weight_en;
    assign bus16.addr       = bus.addr;
    assign bus16.data_in    = bus.data_in;
    assign bus16.start      = bus.start;
    assign bus16.out_ready  = bus.out_ready;

    custom_buff_mac #(.DATA_W(DATA_W), .LANES(LANES), .ADDR_W(ADDR_W), .ACC_W(18)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    custom_buff_mac #(.DATA_W(DATA_W), .LANES(LANES), .ADDR_W(ADDR_W), .ACC_W(16)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Reference operand image: what the buffers should hold.
    int f_m [LANES];
    int w_m [LANES];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic longint dot();
        longint s = 0;
        for (int i = 0; i < LANES; i++) begin
            s += longint'(f_m[i]) * longint'(w_m[i]);
        end
        return s;
    endfunction

    task automatic load(input bit fe, input bit we, input int a, input int d);
        bus.feature_en = fe;
        bus.weight_en  = we;
        bus.addr       = ADDR_W'(a);
        bus.data_in    = DATA_W'(d);
        if (fe) f_m[a] = d;
        if (we) w_m[a] = d;
        step();
        bus.feature_en = 1'b0;
        bus.weight_en  = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < LANES; i++) begin
            f_m[i] = 0;
            w_m[i] = 0;
        end
    endtask

    // One full transaction: start (optionally with a same-cycle feature load),
    // optional write/start poke during RUN, backpressure, accept.
    task automatic run(input string tag, input int bp, input bit poke,
                       input bit ld, input int la, input int ldat, input bit start_acc);
        longint      d;
        logic [63:0] e18, e16, es16;
        bus.start = 1'b1;
        if (ld) begin
            bus.feature_en = 1'b1;
            bus.addr       = ADDR_W'(la);
            bus.data_in    = DATA_W'(ldat);
            f_m[la]        = ldat;
        end
        d   = dot();
        e18 = 64'(d % 262144);
`ifdef CUSTOM_MAC_SAT_EN
        es16 = (d >= 65536) ? 64'd1 : 64'd0;
        e16  = (d >= 65536) ? 64'd65535 : 64'(d);
`else
        es16 = 64'd0;
        e16  = 64'(d % 65536);
`endif
        step();
        bus.start      = 1'b0;
        bus.feature_en = 1'b0;
        chk({tag, "_busy_run"}, 64'(bus.busy), 64'd1);
        for (int e = 2; e <= LANES; e++) begin
            if (poke && e == 2) begin
                bus.feature_en = 1'b1;
                bus.weight_en  = 1'b1;
                bus.addr       = '0;
                bus.data_in    = 8'd9;
                bus.start      = 1'b1;
            end
            step();
            bus.feature_en = 1'b0;
            bus.weight_en  = 1'b0;
            bus.start      = 1'b0;
        end
        chk({tag, "_valid_early"}, 64'(bus.out_valid), 64'd0);
        step();
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_busy_done"}, 64'(bus.busy), 64'd1);
        chk({tag, "_acc18"}, 64'(bus.acc_out), e18);
        chk({tag, "_acc16"}, 64'(bus16.acc_out), e16);
        chk({tag, "_sat16"}, 64'(bus16.sat), es16);
        chk({tag, "_sat18"}, 64'(bus.sat), 64'd0);
        for (int c = 0; c < bp; c++) begin
            step();
            chk({tag, "_bp_valid"}, 64'(bus.out_valid), 64'd1);
            chk({tag, "_bp_acc"}, 64'(bus.acc_out), e18);
        end
        bus.out_ready = 1'b1;
        bus.start     = start_acc;
        step();
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        chk({tag, "_valid_off"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_busy_off"}, 64'(bus.busy), 64'd0);
        chk({tag, "_acc_hold"}, 64'(bus.acc_out), e18);
        if (start_acc) begin
            step();
            chk({tag, "_no_restart"}, 64'(bus.busy), 64'd0);
        end
    endtask

    initial begin
        bus.feature_en = 1'b0;
        bus.weight_en  = 1'b0;
        bus.addr       = '0;
        bus.data_in    = '0;
        bus.start      = 1'b0;
        bus.out_ready  = 1'b0;
        clear_model();

        step();
        step();
        chk("rst_busy",  64'(bus.busy), 64'd0);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_acc",   64'(bus.acc_out), 64'd0);
        chk("rst_sat",   64'(bus16.sat), 64'd0);
        rst = 1'b0;
        step();

        // Asynchronous reset in the middle of a RUN wipes buffers and result.
        for (int i = 0; i < LANES; i++) load(1'b1, 1'b1, i, 10 + i);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        #3 rst = 1'b1;
        #1;
        chk("arst_busy",  64'(bus.busy), 64'd0);
        chk("arst_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_acc",   64'(bus.acc_out), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        clear_model();
        run("after_rst", 0, 1'b0, 1'b0, 0, 0, 1'b0);

        // 1..4 . 5..8 = 70 with 10 cycles of backpressure.
        for (int i = 0; i < LANES; i++) begin
            load(1'b1, 1'b0, i, i + 1);
            load(1'b0, 1'b1, i, i + 5);
        end
        run("dot70", 10, 1'b0, 1'b0, 0, 0, 1'b0);

        // Writes and start during RUN are ignored; start on accept is ignored.
        run("frozen", 2, 1'b1, 1'b0, 0, 0, 1'b1);
        // Same-cycle load + start: 9*5 + 2*6 + 3*7 + 4*8 = 110.
        run("ld_start", 0, 1'b0, 1'b1, 0, 9, 1'b0);

        // out_ready while idle has no effect.
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("idle_ready_valid", 64'(bus.out_valid), 64'd0);
        chk("idle_ready_busy",  64'(bus.busy), 64'd0);

        // All-ones operands: 260100 on 18 bits; wrap or clamp on 16 bits.
        for (int i = 0; i < LANES; i++) load(1'b1, 1'b1, i, 255);
        run("max", 1, 1'b0, 1'b0, 0, 0, 1'b0);

        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < LANES; i++) begin
                int fv, wv;
                fv = ($urandom_range(3) == 0) ? 255 : int'($urandom_range(255));
                wv = ($urandom_range(3) == 0) ? 255 : int'($urandom_range(255));
                if ($urandom_range(3) == 0) begin
                    load(1'b1, 1'b1, i, fv);
                end else begin
                    load(1'b1, 1'b0, i, fv);
                    load(1'b0, 1'b1, i, wv);
                end
            end
            run("rand", int'($urandom_range(3)), 1'(($urandom_range(1))),
                1'(($urandom_range(1))), int'($urandom_range(LANES - 1)),
                int'($urandom_range(255)), 1'(($urandom_range(1))));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
